jedro_1_trap_ctrl: RTL
======================

Name: jedro_1_trap_ctrl

Overview:
Sequences machine-mode trap entry and exit for the jedro_1 core. It accepts synchronous exceptions from decode and the LSU, ecall/ebreak, mret and the three machine interrupt lines. It flushes the pipeline, produces the mepc/mcause/mtval/mstatus updates for the CSR file, and redirects fetch to mtvec or mepc. It sits between the decoder/LSU, the CSR file and the fetch unit.

Parameters:
DATA_WIDTH, 32, datapath width.
IRQ_SYNC_EN, 1, 1 = two-flop synchroniser on irq_*_i; 0 = inputs used directly.

Ports:
clk_i  in  1  clock
rstn_i  in  1  reset, synchronous, active-low
ex_valid_i  in  1  exception reported this cycle
ex_cause_i  in  4  exception mcause code (0, 2, 3, 4, 5, 6, 11)
ex_pc_i  in  32  pc of faulting instruction
ex_tval_i  in  32  mtval value for exception
mret_i  in  1  mret reached execute
retire_i  in  1  instruction retired this cycle (interrupt boundary)
next_pc_i  in  32  pc of next unexecuted instruction
irq_ext_i / irq_timer_i / irq_sw_i  in  1 each  level-sensitive interrupt lines
mstatus_mie_i  in  1  current mstatus.MIE
mie_i  in  32  current mie CSR
mtvec_i  in  32  current mtvec CSR
mepc_i  in  32  current mepc CSR
redirect_ready_i  in  1  fetch accepted redirect
flush_o  out  1  kill all in-flight instructions
busy_o  out  1  trap sequence in progress; decoder stalls
trap_we_o  out  1  CSR file writes mepc, mcause, mtval and mstatus fields this cycle
mret_we_o  out  1  CSR file restores mstatus this cycle
mepc_wdata_o / mcause_wdata_o / mtval_wdata_o  out  32 each  write data
mstatus_mie_wdata_o / mstatus_mpie_wdata_o  out  1 each  write data
redirect_valid_o  out  1  redirect request to fetch
redirect_pc_o  out  32  redirect target

Behaviour:
- Reset (rstn_i low at a clock edge): FSM to IDLE; all outputs 0; latched cause, pc and tval cleared; synchroniser flops cleared. This applies mid-sequence as well.
- Event sampling happens only in IDLE. Priority: ex_valid_i > mret_i > interrupt.
- Interrupt is taken only when all hold: retire_i, mstatus_mie_i, and (pending & mie_i) != 0.
  - Pending bits: bit 11 = ext, bit 7 = timer, bit 3 = sw.
  - Interrupt priority: ext (11) > sw (3) > timer (7).
- Latches on acceptance:
  - Exception: cause = {0, 27'b0, ex_cause_i}, epc = ex_pc_i, tval = ex_tval_i.
  - Interrupt: cause = {1, 27'b0, code}, epc = next_pc_i, tval = 0.
- FSM states: IDLE, FLUSH, UPDATE, REDIRECT.
  - IDLE to FLUSH on an accepted event.
  - FLUSH: flush_o=1 and busy_o=1 for exactly one cycle, then UPDATE.
  - UPDATE, trap case: trap_we_o=1 for one cycle; mepc_wdata=epc with bits [1:0] forced to 0; mcause_wdata=cause; mtval_wdata=tval; mstatus_mpie_wdata=mstatus_mie_i; mstatus_mie_wdata=0.
  - UPDATE, mret case: mret_we_o=1; mstatus_mie_wdata=mstatus_mpie (held as a CSR-side value); mstatus_mpie_wdata=1. Target is latched as mepc_i.
  - UPDATE always goes to REDIRECT.
  - REDIRECT: redirect_valid_o=1 and busy_o=1. redirect_pc_o is stable until redirect_ready_i. On ready, go to IDLE.
- Redirect target:
  - Trap: mtvec_i[31:2]<<2 when mtvec_i[1:0]==00, or when it is 01 and the cause is an exception.
  - Trap, vectored interrupt (mtvec_i[1:0]==01): base + 4*code.
  - Mode values 10/11 are treated as direct.
- Latency: event in IDLE at cycle N gives flush_o at N+1, CSR write at N+2, redirect_valid_o from N+3. Minimum sequence is 4 cycles.
- Events while busy_o=1 are ignored. They are not queued; the upstream core is stalled. Level interrupts remain pending and are re-evaluated in IDLE.
- ex_valid_i and mret_i asserted together: exception wins and mret is dropped.
- Interrupt pending without retire_i: no action.
- mcause and mepc arithmetic is 32-bit with no overflow checks. Vectored target wraps modulo 2^32.

Decomposition:
- Add to jedro_1_defines:
  - typedef trap_state_e {IDLE, FLUSH, UPDATE, REDIRECT}
  - CSR_MCAUSE_IRQ_BIT=31
  - CSR_MCAUSE_M_SW_IRQ=3, CSR_MCAUSE_M_TIMER_IRQ=7, CSR_MCAUSE_M_EXT_IRQ=11
  - MTVEC_MODE_DIRECT=2'b00, MTVEC_MODE_VECTORED=2'b01
- Sub-module jedro_1_irq_prio holds the optional synchroniser, the masking with mie_i/mstatus_mie_i, and the priority encoder. Outputs: irq_take, irq_code[3:0].

Test Plan:
- Illegal instruction: ex_valid_i, cause=2, pc=0x8000_0010, tval=0x0000_FFFF, mtvec=0x0040_0000 → flush at N+1; trap_we at N+2 with mcause=2, mepc=0x8000_0010, mtval=0x0000_FFFF, MIE=0; redirect to 0x0040_0000 at N+3.
- Vectored timer irq: mtvec=0x0040_0001, mie=0x80, MIE=1, irq_timer=1, retire_i, next_pc=0x8000_0104 → mcause=0x8000_0007, mepc=0x8000_0104, redirect 0x0040_001C.
- Simultaneous ext+sw+timer with mie=0x888 → mcause=0x8000_000B. With mie=0x088 → 0x8000_0003.
- mret with mepc_i=0x8000_0200, MPIE=1 → mret_we with MIE=1, MPIE=1; redirect 0x8000_0200.
- ex_valid_i and mret_i same cycle, then a second ex_valid_i during FLUSH → exactly one trap_we pulse; second event ignored. Hold redirect_ready_i low 5 cycles → redirect_pc stable.
- rstn_i low during UPDATE → next cycle IDLE with all outputs 0. MIE=0 with irq pending → no sequence.

Source files
------------

// File: rtl/jedro_1_defines.sv
// Shared trap/CSR definitions for the jedro_1 core: trap FSM states,
// mcause interrupt codes and mtvec mode encodings.
package jedro_1_defines;

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    FLUSH    = 2'b01,
    UPDATE   = 2'b10,
    REDIRECT = 2'b11
  } trap_state_e;

  localparam int          CSR_MCAUSE_IRQ_BIT     = 31;
  localparam logic [3:0]  CSR_MCAUSE_M_SW_IRQ    = 4'd3;
  localparam logic [3:0]  CSR_MCAUSE_M_TIMER_IRQ = 4'd7;
  localparam logic [3:0]  CSR_MCAUSE_M_EXT_IRQ   = 4'd11;

  localparam logic [1:0]  MTVEC_MODE_DIRECT      = 2'b00;
  localparam logic [1:0]  MTVEC_MODE_VECTORED    = 2'b01;

  function automatic logic mtvec_is_vectored(input logic [1:0] mode);
    return mode == MTVEC_MODE_VECTORED;
  endfunction

endpackage

// File: rtl/jedro_1_irq_prio.sv
// Machine interrupt qualification: optional two-flop synchroniser, masking
// with mie/mstatus.MIE at an instruction boundary, and fixed priority pick.
module jedro_1_irq_prio
  import jedro_1_defines::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter bit IRQ_SYNC_EN = 1'b1
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  irq_ext_i,
  input  logic                  irq_timer_i,
  input  logic                  irq_sw_i,
  input  logic                  retire_i,
  input  logic                  mstatus_mie_i,
  input  logic [DATA_WIDTH-1:0] mie_i,
  output logic                  irq_take_o,
  output logic [3:0]            irq_code_o
);

  logic [2:0]            irq_raw;
  logic [2:0]            irq_lvl;
  logic [DATA_WIDTH-1:0] pending;
  logic [DATA_WIDTH-1:0] enabled;

  assign irq_raw = {irq_ext_i, irq_timer_i, irq_sw_i};

  generate
    if (IRQ_SYNC_EN) begin : g_sync
      logic [2:0] meta_q, meta_d;
      logic [2:0] sync_q, sync_d;

      always_comb begin
        meta_d = irq_raw;
        sync_d = meta_q;
      end

      always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
          meta_q <= '0;
          sync_q <= '0;
        end else begin
          meta_q <= meta_d;
          sync_q <= sync_d;
        end
      end

      assign irq_lvl = sync_q;
    end else begin : g_nosync
      assign irq_lvl = irq_raw;
    end
  endgenerate

  always_comb begin
    pending                         = '0;
    pending[CSR_MCAUSE_M_EXT_IRQ]   = irq_lvl[2];
    pending[CSR_MCAUSE_M_TIMER_IRQ] = irq_lvl[1];
    pending[CSR_MCAUSE_M_SW_IRQ]    = irq_lvl[0];
    enabled                         = pending & mie_i;

    // Priority order is ext > sw > timer, not numeric order of the codes.
    irq_code_o = '0;
    if (enabled[CSR_MCAUSE_M_EXT_IRQ]) begin
      irq_code_o = CSR_MCAUSE_M_EXT_IRQ;
    end else if (enabled[CSR_MCAUSE_M_SW_IRQ]) begin
      irq_code_o = CSR_MCAUSE_M_SW_IRQ;
    end else if (enabled[CSR_MCAUSE_M_TIMER_IRQ]) begin
      irq_code_o = CSR_MCAUSE_M_TIMER_IRQ;
    end

    irq_take_o = retire_i && mstatus_mie_i && (enabled != '0);
  end

endmodule

// File: rtl/jedro_1_trap_ctrl.sv
// Machine-mode trap entry/exit sequencer: flush, CSR update, fetch redirect.
// Every output is registered; a sequence takes at least four cycles.
module jedro_1_trap_ctrl
  import jedro_1_defines::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter bit IRQ_SYNC_EN = 1'b1
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  ex_valid_i,
  input  logic [3:0]            ex_cause_i,
  input  logic [DATA_WIDTH-1:0] ex_pc_i,
  input  logic [DATA_WIDTH-1:0] ex_tval_i,
  input  logic                  mret_i,
  input  logic                  retire_i,
  input  logic [DATA_WIDTH-1:0] next_pc_i,
  input  logic                  irq_ext_i,
  input  logic                  irq_timer_i,
  input  logic                  irq_sw_i,
  input  logic                  mstatus_mie_i,
  input  logic [DATA_WIDTH-1:0] mie_i,
  input  logic [DATA_WIDTH-1:0] mtvec_i,
  input  logic [DATA_WIDTH-1:0] mepc_i,
  input  logic                  redirect_ready_i,
  output logic                  flush_o,
  output logic                  busy_o,
  output logic                  trap_we_o,
  output logic                  mret_we_o,
  output logic [DATA_WIDTH-1:0] mepc_wdata_o,
  output logic [DATA_WIDTH-1:0] mcause_wdata_o,
  output logic [DATA_WIDTH-1:0] mtval_wdata_o,
  output logic                  mstatus_mie_wdata_o,
  output logic                  mstatus_mpie_wdata_o,
  output logic                  redirect_valid_o,
  output logic [DATA_WIDTH-1:0] redirect_pc_o
);

  localparam logic [DATA_WIDTH-1:0] ALIGN_MASK = {{(DATA_WIDTH-2){1'b1}}, 2'b00};

  logic       irq_take;
  logic [3:0] irq_code;

  jedro_1_irq_prio #(
    .DATA_WIDTH  (DATA_WIDTH),
    .IRQ_SYNC_EN (IRQ_SYNC_EN)
  ) u_irq_prio (
    .clk_i         (clk_i),
    .rstn_i        (rstn_i),
    .irq_ext_i     (irq_ext_i),
    .irq_timer_i   (irq_timer_i),
    .irq_sw_i      (irq_sw_i),
    .retire_i      (retire_i),
    .mstatus_mie_i (mstatus_mie_i),
    .mie_i         (mie_i),
    .irq_take_o    (irq_take),
    .irq_code_o    (irq_code)
  );

  trap_state_e           state_q, state_d;
  logic                  is_mret_q, is_mret_d;
  logic [DATA_WIDTH-1:0] cause_q, cause_d;
  logic [DATA_WIDTH-1:0] epc_q, epc_d;
  logic [DATA_WIDTH-1:0] tval_q, tval_d;
  // Shadow of mstatus.MPIE: only trap entry and mret ever modify it.
  logic                  mpie_q, mpie_d;

  logic                  flush_q, flush_d;
  logic                  busy_q, busy_d;
  logic                  trap_we_q, trap_we_d;
  logic                  mret_we_q, mret_we_d;
  logic [DATA_WIDTH-1:0] mepc_wdata_q, mepc_wdata_d;
  logic [DATA_WIDTH-1:0] mcause_wdata_q, mcause_wdata_d;
  logic [DATA_WIDTH-1:0] mtval_wdata_q, mtval_wdata_d;
  logic                  mie_wdata_q, mie_wdata_d;
  logic                  mpie_wdata_q, mpie_wdata_d;
  logic                  redirect_valid_q, redirect_valid_d;
  logic [DATA_WIDTH-1:0] redirect_pc_q, redirect_pc_d;

  logic [DATA_WIDTH-1:0] trap_base;
  logic [DATA_WIDTH-1:0] vec_off;
  logic [DATA_WIDTH-1:0] trap_target;

  // Vectored mode only offsets interrupts; exceptions and modes 10/11 go to base.
  always_comb begin
    trap_base    = mtvec_i & ALIGN_MASK;
    vec_off      = '0;
    vec_off[5:2] = cause_q[3:0];
    trap_target  = trap_base;
    if (mtvec_is_vectored(mtvec_i[1:0]) && cause_q[CSR_MCAUSE_IRQ_BIT]) begin
      trap_target = trap_base + vec_off;
    end
  end

  always_comb begin
    state_d          = state_q;
    is_mret_d        = is_mret_q;
    cause_d          = cause_q;
    epc_d            = epc_q;
    tval_d           = tval_q;
    mpie_d           = mpie_q;
    flush_d          = 1'b0;
    busy_d           = busy_q;
    trap_we_d        = 1'b0;
    mret_we_d        = 1'b0;
    mepc_wdata_d     = '0;
    mcause_wdata_d   = '0;
    mtval_wdata_d    = '0;
    mie_wdata_d      = 1'b0;
    mpie_wdata_d     = 1'b0;
    redirect_valid_d = redirect_valid_q;
    redirect_pc_d    = redirect_pc_q;

    case (state_q)
      IDLE: begin
        busy_d           = 1'b0;
        redirect_valid_d = 1'b0;
        redirect_pc_d    = '0;
        if (ex_valid_i) begin
          state_d         = FLUSH;
          is_mret_d       = 1'b0;
          cause_d         = '0;
          cause_d[3:0]    = ex_cause_i;
          epc_d           = ex_pc_i;
          tval_d          = ex_tval_i;
          flush_d         = 1'b1;
          busy_d          = 1'b1;
        end else if (mret_i) begin
          state_d         = FLUSH;
          is_mret_d       = 1'b1;
          flush_d         = 1'b1;
          busy_d          = 1'b1;
        end else if (irq_take) begin
          state_d                     = FLUSH;
          is_mret_d                   = 1'b0;
          cause_d                     = '0;
          cause_d[CSR_MCAUSE_IRQ_BIT] = 1'b1;
          cause_d[3:0]                = irq_code;
          epc_d                       = next_pc_i;
          tval_d                      = '0;
          flush_d                     = 1'b1;
          busy_d                      = 1'b1;
        end
      end

      FLUSH: begin
        state_d = UPDATE;
        if (is_mret_q) begin
          mret_we_d    = 1'b1;
          mie_wdata_d  = mpie_q;
          mpie_wdata_d = 1'b1;
          mpie_d       = 1'b1;
        end else begin
          trap_we_d      = 1'b1;
          mepc_wdata_d   = epc_q & ALIGN_MASK;
          mcause_wdata_d = cause_q;
          mtval_wdata_d  = tval_q;
          mie_wdata_d    = 1'b0;
          mpie_wdata_d   = mstatus_mie_i;
          mpie_d         = mstatus_mie_i;
        end
      end

      UPDATE: begin
        state_d          = REDIRECT;
        redirect_valid_d = 1'b1;
        redirect_pc_d    = is_mret_q ? mepc_i : trap_target;
      end

      REDIRECT: begin
        if (redirect_ready_i) begin
          state_d          = IDLE;
          busy_d           = 1'b0;
          redirect_valid_d = 1'b0;
          redirect_pc_d    = '0;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_q          <= IDLE;
      is_mret_q        <= 1'b0;
      cause_q          <= '0;
      epc_q            <= '0;
      tval_q           <= '0;
      mpie_q           <= 1'b0;
      flush_q          <= 1'b0;
      busy_q           <= 1'b0;
      trap_we_q        <= 1'b0;
      mret_we_q        <= 1'b0;
      mepc_wdata_q     <= '0;
      mcause_wdata_q   <= '0;
      mtval_wdata_q    <= '0;
      mie_wdata_q      <= 1'b0;
      mpie_wdata_q     <= 1'b0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
    end else begin
      state_q          <= state_d;
      is_mret_q        <= is_mret_d;
      cause_q          <= cause_d;
      epc_q            <= epc_d;
      tval_q           <= tval_d;
      mpie_q           <= mpie_d;
      flush_q          <= flush_d;
      busy_q           <= busy_d;
      trap_we_q        <= trap_we_d;
      mret_we_q        <= mret_we_d;
      mepc_wdata_q     <= mepc_wdata_d;
      mcause_wdata_q   <= mcause_wdata_d;
      mtval_wdata_q    <= mtval_wdata_d;
      mie_wdata_q      <= mie_wdata_d;
      mpie_wdata_q     <= mpie_wdata_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
    end
  end

  assign flush_o              = flush_q;
  assign busy_o               = busy_q;
  assign trap_we_o            = trap_we_q;
  assign mret_we_o            = mret_we_q;
  assign mepc_wdata_o         = mepc_wdata_q;
  assign mcause_wdata_o       = mcause_wdata_q;
  assign mtval_wdata_o        = mtval_wdata_q;
  assign mstatus_mie_wdata_o  = mie_wdata_q;
  assign mstatus_mpie_wdata_o = mpie_wdata_q;
  assign redirect_valid_o     = redirect_valid_q;
  assign redirect_pc_o        = redirect_pc_q;

endmodule
